// File: rtl/zoom_line_reader.sv
// zoom_line_reader: fetches one line from the zoom RAM and emits a nearest-neighbour rescaled pixel stream
module zoom_line_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH:0]             line_len,
  input  logic [ADDR_WIDTH:0]             out_len,
  input  logic [ADDR_WIDTH+FRAC_BITS-1:0] step,
  output logic                            busy,
  output logic                            done,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]           ram_rd_data,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last
);
  localparam int AW = ADDR_WIDTH;
  localparam int SW = AW + FRAC_BITS;
  localparam int ACW = SW + 1;
  localparam logic [AW:0] ONE = 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                r_state;
  logic [AW:0]           r_line_len, r_out_len, r_issued, r_beats;
  logic [SW-1:0]         r_step;
  logic [ACW-1:0]        r_acc;
  logic                  r_inflight, r_rd_ptr, r_wr_ptr;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  w_pop, w_issue;
  logic [AW:0]           w_idx, w_lim, w_addr;
  logic [ACW:0]          w_sum;
  assign m_valid = r_cnt != 2'd0;
  assign w_pop = m_valid && m_ready;
  // a beat leaving this cycle frees its slot, which keeps 1 pixel/clk without overflow
  assign w_issue = r_state == S_RUN &&
                   ({2'b0, r_inflight} + {1'b0, r_cnt} - {2'b0, w_pop}) < 3'd2;
  assign w_idx = r_acc[ACW-1:FRAC_BITS];
  assign w_lim = r_line_len - ONE;
  assign w_addr = w_idx > w_lim ? w_lim : w_idx;
  assign w_sum = {1'b0, r_acc} + {2'b0, r_step};
  assign ram_rd_en = w_issue;
  assign ram_rd_addr = w_issue ? w_addr[AW-1:0] : '0;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign m_data = m_valid ? r_fifo[r_rd_ptr] : '0;
  assign m_last = m_valid && r_beats == r_out_len - ONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_line_len <= '0;
      r_out_len  <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_issued   <= '0;
      r_beats    <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_cnt      <= '0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
    end else begin
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= ram_rd_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_beats  <= r_beats + ONE;
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;
      if (w_issue) begin
        r_acc    <= w_sum[ACW] ? '1 : w_sum[ACW-1:0];
        r_issued <= r_issued + ONE;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_line_len <= line_len;
          r_out_len  <= out_len;
          r_step     <= step;
          r_acc      <= '0;
          r_issued   <= '0;
          r_beats    <= '0;
          r_state    <= out_len != '0 ? S_RUN : S_DONE;
        end
        S_RUN:   if (w_issue && r_issued == r_out_len - ONE) r_state <= S_DRAIN;
        S_DRAIN: if (w_pop && r_beats == r_out_len - ONE) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zoom_line_reader.sv
// tb_zoom_line_reader: scoreboard bench for zoom_line_reader with a 1-cycle-latency RAM model
module tb_zoom_line_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b1;
  logic [11:0] line_len = '0, out_len = '0;
  logic [22:0] step = '0;
  logic        busy, done, ram_rd_en, m_valid, m_last;
  logic [10:0] ram_rd_addr;
  logic [15:0] ram_rd_data = '0, m_data;
  logic [15:0] mem [2048];
  int n_vec = 0, n_err = 0, cyc = 0, n_iss = 0, n_pop = 0;
  int first_v = -1, last_cyc = -1, bp = 0;
  bit act = 0, stalled = 0, held_l = 0;
  logic [15:0] held_d = '0;
  int plan [$];
  int exp_addr [$];
  logic [15:0] exp_data [$];
  bit exp_last [$];

  zoom_line_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_len(line_len), .out_len(out_len),
    .step(step), .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 m_ready = bp != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (rst_n) begin
    if (busy) chk("outstanding_le2", 64'(n_iss - n_pop <= 2), 64'd1);
    if (ram_rd_en || m_valid) act = 1;
    if (ram_rd_en) begin
      n_iss++;
      if (exp_addr.size() == 0) chk("unexpected_read", 64'(ram_rd_addr), 64'h7FF_FFFF);
      else chk("rd_addr", 64'(ram_rd_addr), 64'(exp_addr.pop_front()));
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (stalled) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, held_l, held_d});
    stalled = m_valid && !m_ready;
    held_d = m_data;
    held_l = m_last;
    if (m_valid && m_ready) begin
      n_pop++;
      if (m_last) last_cyc = cyc;
      if (exp_data.size() == 0) chk("unexpected_beat", 64'(m_data), 64'hDEAD_0000);
      else begin
        chk("beat_data", 64'(m_data), 64'(exp_data.pop_front()));
        chk("beat_last", 64'(m_last), 64'(exp_last.pop_front()));
      end
    end
  end

  task automatic load_plan(input int ol);
    for (int k = 0; k < ol; k++) begin
      exp_addr.push_back(plan[k]);
      exp_data.push_back(16'hFFFF - 16'(plan[k]));
      exp_last.push_back(k == ol - 1);
    end
  endtask

  task automatic pulse_start(input int ll, input int ol, input int st);
    @(posedge clk);
    #1 start = 1; line_len = 12'(ll); out_len = 12'(ol); step = 23'(st);
  endtask

  task automatic run_line(input int ll, input int ol, input int st, input int bpm, input bit mid);
    int s, t;
    load_plan(ol);
    act = 0; first_v = -1; last_cyc = -1; bp = bpm;
    pulse_start(ll, ol, st);
    @(negedge clk) s = cyc;
    @(posedge clk) #1 start = 0;
    if (mid) begin
      repeat (4) @(posedge clk);
      #1 start = 1; line_len = 12'd3; out_len = 12'd2; step = 23'd0;
      @(posedge clk) #1 start = 0;
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 2000);
    chk("done_seen", 64'(done), 64'd1);
    if (done) begin
      chk("done_cycle", 64'(cyc), 64'(ol == 0 ? s + 1 : last_cyc + 1));
      chk("exp_drained", 64'(exp_data.size() + exp_addr.size()), 64'd0);
      if (ol == 0) chk("zero_len_quiet", 64'(act), 64'd0);
      if (bpm == 0 && ol > 0 && !mid) chk("first_valid_lat", 64'(first_v), 64'(s + 3));
      @(negedge clk);
      chk("done_pulse_idle", {done, busy}, 2'b00);
    end
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    bp = 0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'hFFFF - 16'(i);
    #23;
    chk("reset_outputs", {busy, done, ram_rd_en, ram_rd_addr, m_valid, m_last, m_data}, '0);
    @(negedge clk) rst_n = 1;
    // identity
    plan.delete(); for (int k = 0; k < 16; k++) plan.push_back(k);
    run_line(16, 16, 'h1000, 0, 0);
    // 2x upscale
    plan.delete(); for (int k = 0; k < 16; k++) plan.push_back(k / 2);
    run_line(8, 16, 'h0800, 0, 0);
    // downscale, last address clamped from 10 to 9
    plan = '{0, 1, 3, 4, 6, 7, 9, 9};
    run_line(10, 8, 'h1800, 0, 0);
    // identity under random backpressure
    plan.delete(); for (int k = 0; k < 16; k++) plan.push_back(k);
    run_line(16, 16, 'h1000, 1, 0);
    // empty line, then start mid-run ignored
    plan.delete();
    run_line(16, 0, 'h1000, 0, 0);
    plan.delete(); for (int k = 0; k < 16; k++) plan.push_back(k);
    run_line(16, 16, 'h1000, 0, 1);
    // step 0 repeats pixel 0
    plan.delete(); for (int k = 0; k < 5; k++) plan.push_back(0);
    run_line(16, 5, 0, 0, 0);
    // asynchronous reset after 5 beats
    plan.delete(); for (int k = 0; k < 16; k++) plan.push_back(k);
    load_plan(16);
    begin
      int base = n_pop, t = 0;
      pulse_start(16, 16, 'h1000);
      @(posedge clk) #1 start = 0;
      while (n_pop - base < 5 && t < 200) begin @(negedge clk); t++; end
      chk("five_beats_seen", 64'(n_pop - base >= 5), 64'd1);
    end
    @(posedge clk) #2 rst_n = 0;
    #1 chk("async_reset", {busy, done, ram_rd_en, ram_rd_addr, m_valid, m_last, m_data}, '0);
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    stalled = 0; n_iss = 0; n_pop = 0;
    @(negedge clk) rst_n = 1;
    run_line(16, 16, 'h1000, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
